ctr_arb: RTL and testbench
==========================

Name: ctr_arb

Overview:
Round-robin arbiter and sequencer that shares one `ctr` 4-state control FSM instance among NREQ requesters. It grants exclusive ownership to one requester and steers that requester's ctrl bit into the shared `ctr`. It returns the `ctr` output to the grantee. Between owners it issues a one-cycle reset to the `ctr`, so every grant starts from `ctr` state 0. It sits between the requesting control units and the single shared `ctr` instance.

Parameters:
NREQ, 4, number of requesters (>=1)
MAX_HOLD, 16, maximum ownership cycles per grant; 0 = unlimited
IDW, $clog2(NREQ) (min 1), width of gnt_id

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
req  in  NREQ  per-requester level request; held high for the whole ownership
ctrl_in  in  NREQ  per-requester ctrl bit destined for the shared ctr
ctr_O  in  4  O output of the shared ctr
ctr_rst  out  1  rst of the shared ctr
ctr_ctrl  out  1  ctrl of the shared ctr
gnt  out  NREQ  one-hot ownership grant
gnt_id  out  IDW  index of current/last grantee
o_data  out  4  ctr_O forwarded (broadcast)
o_valid  out  NREQ  one-hot: o_data belongs to this requester
timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD
busy  out  1  state != IDLE

Behaviour:
- States:
  - FLUSH: ctr reset cycle.
  - IDLE: arbitration.
  - OWN: grant active.
- rst high forces:
  - state=FLUSH, rr pointer=0, hold counter=0.
  - gnt=0, gnt_id=0, o_valid=0, timeout=0.
- Outputs decoded from state:
  - ctr_rst = (state==FLUSH), so it is 1 during reset.
  - ctr_ctrl = (state==OWN) ? ctrl_in[gnt_id] : 0 (combinational).
  - o_data = ctr_O (combinational).
- FLUSH:
  - Lasts exactly 1 cycle, then IDLE.
  - After rst deasserts, exactly one FLUSH cycle precedes IDLE.
- IDLE, arbitration:
  - If any req is set, select the first set bit scanning from the rr pointer upward, wrapping at NREQ-1 to 0.
  - Next edge: gnt one-hot, gnt_id = winner, state=OWN, hold=0.
  - Latency: req seen in IDLE at edge t gives gnt high after edge t.
- OWN:
  - gnt and gnt_id are stable.
  - Requests from other requesters are ignored; no queueing, req is a level.
  - hold increments every OWN cycle, saturating.
- o_valid:
  - Registered. o_valid[gnt_id] = 1 from the 2nd OWN cycle through the last OWN cycle, i.e. once ctr_O reflects grantee ctrl.
  - 0 in the first OWN cycle and in all other states.
- Release (normal): req[gnt_id]==0 sampled in OWN. Next edge:
  - gnt=0, o_valid=0, state=FLUSH.
  - rr pointer = (gnt_id+1) mod NREQ.
- Release (timeout): MAX_HOLD!=0, hold==MAX_HOLD-1 and req[gnt_id] still 1. Next edge:
  - Same as normal release.
  - timeout=1 for exactly that FLUSH cycle.
- Simultaneous req drop and timeout condition: treated as normal release; no timeout pulse.
- A timed-out requester may keep req high. It is re-arbitrated at lowest priority because the pointer has moved past it.
- Turnaround from last OWN cycle to next gnt: FLUSH + IDLE, i.e. gnt low for exactly 2 cycles.
- NREQ=1: pointer stays 0; FLUSH/IDLE still inserted between grants.
- rst mid-OWN: gnt and o_valid drop at the next edge, ctr_rst asserted, no timeout pulse.
- Hold counter width $clog2(MAX_HOLD+1); no wrap.

Decomposition:
- Package ctr_pkg holds:
  - The state enum {FLUSH, IDLE, OWN}.
  - CTR_OW=4 (ctr output width).
  - Named ctr output constants: O_S0_CTRL1=6, O_S0_CTRL0=3, O_S1_CTRL1=1, O_S2_CTRL1=1.
- One sub-module: rr_pick, the combinational round-robin priority picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner, index, any.

Test Plan:
- Single owner, ctr sequence:
  - Stimulus: after reset, req[0]=1, ctrl_in[0]=1 held, real ctr attached.
  - Response: gnt=0001 one cycle after IDLE; o_valid[0] cycles show o_data 6, 1, 1, then 0.
  - Drop req[0]: gnt=0 next edge, ctr_rst=1 exactly 1 cycle.
- Round-robin contention and wrap-around:
  - req=0101 from IDLE → grant 0, then after req[0] drops → grant 2 with gnt low exactly 2 cycles.
  - ctrl_in[2]=0 → first valid o_data for 2 is 3.
  - req=1001 with pointer at 3 → grant 3, then 0.
- Timeout:
  - Stimulus: MAX_HOLD=4, req[1] held.
  - Response: gnt[1] exactly 4 cycles, timeout=1 one cycle coincident with ctr_rst=1, then regrant to 1 (sole requester).
  - req[1] dropping in the 4th cycle: no timeout pulse.
- Reset mid-operation:
  - Stimulus: rst in 3rd OWN cycle.
  - Response: gnt=0, o_valid=0, timeout=0, gnt_id=0 next edge; ctr_rst=1 during rst plus 1 cycle after; pointer back to 0, so req=1111 grants 0.
- Non-owner isolation:
  - Stimulus: during ownership by 0, toggle req[3] and ctrl_in[3].
  - Response: ctr_ctrl tracks only ctrl_in[0]; o_valid[3] stays 0.

Source files
------------

// File: rtl/ctr_pkg.sv
// ctr_pkg: types and constants shared by the ctr_arb slice.
//   arb_state_e : arbiter sequencing states (FLUSH / IDLE / OWN).
//   CTR_OW      : width of the shared ctr O output.
//   O_*         : named ctr output values, by ctr state and ctrl input.
package ctr_pkg;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,  // ctr held in reset for one cycle between owners
    IDLE  = 2'd1,  // arbitration cycle
    OWN   = 2'd2   // a requester owns the ctr
  } arb_state_e;

  localparam int CTR_OW = 4;

  localparam logic [CTR_OW-1:0] O_S0_CTRL1 = 4'd6;
  localparam logic [CTR_OW-1:0] O_S0_CTRL0 = 4'd3;
  localparam logic [CTR_OW-1:0] O_S1_CTRL1 = 4'd1;
  localparam logic [CTR_OW-1:0] O_S2_CTRL1 = 4'd1;

endpackage

// File: rtl/ctr_arb_if.sv
// ctr_arb_if: bundle of the requester-side and ctr-side signals of ctr_arb.
//   slave modport  : the arbiter's view (takes req/ctrl_in/ctr_O, drives the rest).
//   master modport : the surrounding logic's view (requesters plus the shared ctr).
//   req, ctrl_in   : per-requester level request and ctrl bit.
//   ctr_O          : output of the shared ctr.
//   ctr_rst/ctr_ctrl : reset and ctrl inputs of the shared ctr.
//   gnt, gnt_id    : one-hot grant and index of current/last grantee.
//   o_data/o_valid : forwarded ctr output and its one-hot owner tag.
//   timeout, busy  : grant-revoked pulse and not-idle flag.
interface ctr_arb_if
  import ctr_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) ();

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   ctrl_in;
  logic [CTR_OW-1:0] ctr_O;
  logic              ctr_rst;
  logic              ctr_ctrl;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_id;
  logic [CTR_OW-1:0] o_data;
  logic [NREQ-1:0]   o_valid;
  logic              timeout;
  logic              busy;

  modport slave (
    input  req, ctrl_in, ctr_O,
    output ctr_rst, ctr_ctrl, gnt, gnt_id, o_data, o_valid, timeout, busy
  );

  modport master (
    output req, ctrl_in, ctr_O,
    input  ctr_rst, ctr_ctrl, gnt, gnt_id, o_data, o_valid, timeout, busy
  );

endinterface

// File: rtl/ctr_arb_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req_i : request vector.
//   ptr_i : highest-priority index; scanning goes upward and wraps to 0.
//   gnt_o : one-hot winner (all zero when nothing requests).
//   idx_o : winner index (0 when nothing requests).
//   any_o : at least one request present.
module rr_pick
  import ctr_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  // (p + k) mod NREQ for p < NREQ and k < NREQ: one conditional subtract suffices.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // cand[k] is the requester sitting k positions above the pointer.
  logic [IDW-1:0] cand [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = wrap_idx(ptr_i, gi);
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest one wins last.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[cand[k]]) begin
        idx_o = cand[k];
        any_o = 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign gnt_o[gi] = any_o && (idx_o == IDW'(gi));
    end
  endgenerate

endmodule

// File: rtl/ctr_arb.sv
// ctr_arb: round-robin arbiter that time-shares one ctr FSM among NREQ
// requesters. The owner's ctrl bit is steered into the ctr and the ctr output
// is tagged back to it; a one-cycle ctr reset separates consecutive owners so
// every grant starts from ctr state 0.
//   clk, rst : clock and synchronous active-high reset.
//   bus      : ctr_arb_if slave modport (requests, ctrl bits, ctr I/O, grant,
//              forwarded data/valid, timeout pulse, busy).
module ctr_arb
  import ctr_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic        clk,
  input logic        rst,
  ctr_arb_if.slave   bus
);

  localparam int             HW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit             HOLD_EN   = (MAX_HOLD > 0);
  localparam logic [HW-1:0]  HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(NREQ - 1);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [NREQ-1:0] o_valid_q, o_valid_d;
  logic            timeout_q, timeout_d;

  logic [NREQ-1:0] pick_oh;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i (bus.req),
    .ptr_i (rr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    o_valid_d = '0;
    timeout_d = 1'b0;

    unique case (state_q)
      FLUSH: state_d = IDLE;

      IDLE: begin
        if (pick_any) begin
          state_d  = OWN;
          gnt_d    = pick_oh;
          gnt_id_d = pick_idx;
          hold_d   = '0;
        end
      end

      OWN: begin
        // A dropped request takes precedence over the hold limit, so a
        // coincident drop never raises timeout.
        if (!bus.req[gnt_id_q] || (HOLD_EN && hold_q == HOLD_LAST)) begin
          state_d   = FLUSH;
          gnt_d     = '0;
          rr_d      = (gnt_id_q == LAST_IDX) ? '0 : gnt_id_q + IDW'(1);
          timeout_d = bus.req[gnt_id_q];
        end else begin
          // ctr_O lags ctr_ctrl by one cycle, so data is tagged valid from
          // the second ownership cycle on.
          o_valid_d = gnt_q;
          if (hold_q != '1) hold_d = hold_q + HW'(1);
        end
      end

      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FLUSH;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      rr_q      <= '0;
      hold_q    <= '0;
      o_valid_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      o_valid_q <= o_valid_d;
      timeout_q <= timeout_d;
    end
  end

  // rst is ORed in so the ctr is held in reset from the first rst cycle,
  // before the state register has been forced to FLUSH.
  assign bus.ctr_rst  = rst || (state_q == FLUSH);
  assign bus.ctr_ctrl = (state_q == OWN) && bus.ctrl_in[gnt_id_q];
  assign bus.gnt      = gnt_q;
  assign bus.gnt_id   = gnt_id_q;
  assign bus.o_data   = bus.ctr_O;
  assign bus.o_valid  = o_valid_q;
  assign bus.timeout  = timeout_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ctr_arb.sv
module tb_ctr_arb;
  import ctr_pkg::*;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctr_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  ctr_arb #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural stand-in for the shared ctr: O registered from (state, ctrl),
  // ctrl=1 walks states 0->1->2->3, ctrl=0 holds.
  logic [3:0] ctr_o_q = '0;
  int         ctr_s   = 0;

  function automatic logic [3:0] ctr_out(input int s, input logic c);
    if (s == 0) return c ? O_S0_CTRL1 : O_S0_CTRL0;
    if (s == 1 && c) return O_S1_CTRL1;
    if (s == 2 && c) return O_S2_CTRL1;
    return 4'd0;
  endfunction

  always @(posedge clk) begin
    if (bus.ctr_rst) begin
      ctr_s   <= 0;
      ctr_o_q <= '0;
    end else begin
      ctr_o_q <= ctr_out(ctr_s, bus.ctr_ctrl);
      if (bus.ctr_ctrl && ctr_s < 3) ctr_s <= ctr_s + 1;
    end
  end
  assign bus.ctr_O = ctr_o_q;

  int n_chk  = 0;
  int n_pass = 0;
  int cycle  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cycle);
  endtask

  // Reference model: who owns the ctr, for how many cycles, and whether this
  // cycle is the reset gap after an owner.
  bit m_known = 0;
  int m_owner = -1;  // -1: nobody owns
  int m_age   = 0;   // ownership cycle number, 1 = first
  int m_last  = 0;
  int m_ptr   = 0;
  bit m_flush = 0;
  bit m_tout  = 0;

  logic [3:0] obs_gnt, obs_ov, obs_od;
  logic [1:0] obs_id;
  logic       obs_tout, obs_crst, obs_ctrl;

  task automatic model_release();
    m_ptr   = (m_owner + 1) % NREQ;
    m_owner = -1;
    m_age   = 0;
    m_flush = 1;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_known = 1; m_owner = -1; m_age = 0; m_last = 0; m_ptr = 0;
      m_flush = 1; m_tout = 0;
    end else if (m_flush) begin
      m_flush = 0;
      m_tout  = 0;
    end else if (m_owner < 0) begin
      m_tout = 0;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (m_owner < 0 && bus.req[i]) begin
          m_owner = i; m_age = 1; m_last = i;
          $display("cycle %0d: grant to requester %0d", cycle, i);
        end
      end
    end else begin
      m_tout = 0;
      if (!bus.req[m_owner]) model_release();
      else if (MAX_HOLD != 0 && m_age == MAX_HOLD) begin
        model_release();
        m_tout = 1;
      end else m_age++;
    end
  endtask

  // One clock cycle: entered at a falling edge with inputs already driven.
  task automatic cyc();
    logic [3:0] e_gnt, e_ov;
    #1;
    obs_gnt = bus.gnt; obs_ov = bus.o_valid; obs_od = bus.o_data; obs_id = bus.gnt_id;
    obs_tout = bus.timeout; obs_crst = bus.ctr_rst; obs_ctrl = bus.ctr_ctrl;
    if (m_known) begin
      e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
      e_ov  = (m_owner >= 0 && m_age >= 2) ? e_gnt : 4'd0;
      check("gnt", bus.gnt, e_gnt);
      check("gnt_id", bus.gnt_id, m_last);
      check("o_valid", bus.o_valid, e_ov);
      check("timeout", bus.timeout, m_tout);
      check("ctr_rst", bus.ctr_rst, rst || m_flush);
      check("ctr_ctrl", bus.ctr_ctrl, (m_owner >= 0) ? bus.ctrl_in[m_owner] : 1'b0);
      check("busy", bus.busy, (m_owner >= 0) || m_flush);
      check("o_data", bus.o_data, ctr_o_q);
    end
    @(posedge clk);
    model_edge();
    cycle++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = '0; bus.ctrl_in = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // Advance until a grant appears (bounded); gap = grant-low cycles seen first.
  task automatic wait_gnt(input int exp_idx, output int gap);
    bit found;
    found = 0; gap = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (obs_gnt != 0) begin found = 1; break; end
      gap++;
    end
    if (!found) check("wait_gnt_expired", 0, 1);
    else check("gnt_winner", obs_gnt, 32'(1 << exp_idx));
  endtask

  initial begin
    int g, cnt;
    bus.req = '0; bus.ctrl_in = '0;
    @(negedge clk);

    // Reset state and single owner ctr sequence (timed out at 4 cycles)
    do_reset();
    check("rst_gnt", obs_gnt, 0);
    check("rst_crst", obs_crst, 1);
    bus.req = 4'b0001; bus.ctrl_in = 4'b0001;
    wait_gnt(0, g);
    check("s1_first_lat", g, 2);
    check("s1_ov_first", obs_ov, 0);
    cyc(); check("s1_od0", obs_od, O_S0_CTRL1); check("s1_ov", obs_ov, 4'b0001);
    cyc(); check("s1_od1", obs_od, O_S1_CTRL1);
    cyc(); check("s1_od2", obs_od, O_S2_CTRL1);
    cyc(); check("s1_od3", obs_od, 0); check("s1_tout", obs_tout, 1); check("s1_crst", obs_crst, 1);
    wait_gnt(0, g);
    check("s1_regrant_gap", g, 1);
    bus.req = '0;
    cyc();
    cyc(); check("s1_drop_gnt", obs_gnt, 0); check("s1_drop_crst", obs_crst, 1); check("s1_drop_tout", obs_tout, 0);
    cyc(); check("s1_idle_crst", obs_crst, 0);

    // Round robin and wrap-around
    do_reset();
    bus.req = 4'b0101; bus.ctrl_in = 4'b0001;
    wait_gnt(0, g);
    cyc();
    bus.req = 4'b0100;
    cyc();
    wait_gnt(2, g);
    check("rr_gap_0_2", g, 2);
    cyc(); check("rr_od_req2", obs_od, O_S0_CTRL0); check("rr_ov2", obs_ov, 4'b0100);
    bus.req = 4'b1001;
    cyc();
    wait_gnt(3, g);
    bus.req = 4'b0001;
    cyc();
    wait_gnt(0, g);
    check("rr_gap_3_0", g, 2);
    bus.req = '0;
    cyc(); cyc();

    // Timeout and drop on the last allowed cycle
    do_reset();
    bus.req = 4'b0010; bus.ctrl_in = 4'b0010;
    wait_gnt(1, g);
    cnt = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (!obs_gnt[1]) break;
      cnt++;
    end
    check("to_len", cnt, MAX_HOLD);
    check("to_pulse", obs_tout, 1);
    check("to_crst", obs_crst, 1);
    wait_gnt(1, g);
    check("to_regrant_gap", g, 1);
    cyc(); cyc();
    bus.req = '0;
    cyc();
    cyc(); check("to_drop_no_pulse", obs_tout, 0); check("to_drop_crst", obs_crst, 1);

    // Reset in the middle of ownership
    do_reset();
    bus.req = 4'b0100;
    wait_gnt(2, g);
    bus.req = '0;
    cyc();
    bus.req = 4'b1111;
    wait_gnt(3, g);
    cyc();
    rst = 1'b1;
    cyc(); check("mr_crst_in_rst", obs_crst, 1);
    rst = 1'b0;
    cyc();
    check("mr_gnt", obs_gnt, 0); check("mr_ov", obs_ov, 0);
    check("mr_tout", obs_tout, 0); check("mr_id", obs_id, 0); check("mr_crst", obs_crst, 1);
    wait_gnt(0, g);
    check("mr_gap", g, 1);

    // Non-owner isolation
    do_reset();
    bus.req = 4'b0001;
    wait_gnt(0, g);
    for (int i = 0; i < 3; i++) begin
      bus.req[3] = 1'($urandom); bus.ctrl_in[3] = 1'($urandom); bus.ctrl_in[0] = 1'($urandom);
      cyc();
      check("iso_ctrl", obs_ctrl, bus.ctrl_in[0]);
      check("iso_ov3", obs_ov[3], 0);
    end

    // Randomised traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 5) == 0) bus.req[b] = ~bus.req[b];
      bus.ctrl_in = 4'($urandom);
      cyc();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
